rib_xbar: RTL and testbench

RIB_XBAR -- requirements
Module: rib_xbar

---
 rtl/rib_xbar.sv | 161 ++++++++++++++++
 tb/tb_rib_xbar.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_xbar.sv
// rib_xbar: register-bus crossbar, NUM_M masters to NUM_S slaves, fixed-priority or round-robin arbitration.
// Latency: grant, slave enables and broadcast address/data in the request cycle; read response one cycle later.
// Backpressure: one transfer per cycle; losing requesters see m_hold_o and keep their request asserted.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   m_req_i/m_we_i          per-master request and write qualifier
//   m_addr_i/m_wdata_i      per-master address / write data, master k at [k*W +: W]
//   m_gnt_o/m_hold_o        one-hot grant (combinational) and per-master stall
//   m_rvalid_o/m_rdata_o    registered one-hot read valid and its data
//   m_err_o                 decode error flag alongside m_rvalid_o
//   s_addr_o/s_wdata_o      broadcast address (top nibble cleared) and write data
//   s_wen_o/s_ren_o         one-hot slave write / read enables
//   s_rdata_i               slave read data, valid one cycle after s_ren_o
module rib_xbar #(
   parameter int NUM_M    = 2,
   parameter int NUM_S    = 8,
   parameter int ARB_MODE = 1,
   parameter int AW       = 32,
   parameter int DW       = 32
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [NUM_M-1:0]    m_req_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_wdata_i,
   output logic [NUM_M-1:0]    m_gnt_o,
   output logic [NUM_M-1:0]    m_hold_o,
   output logic [NUM_M-1:0]    m_rvalid_o,
   output logic [DW-1:0]       m_rdata_o,
   output logic                m_err_o,
   output logic [AW-1:0]       s_addr_o,
   output logic [DW-1:0]       s_wdata_o,
   output logic [NUM_S-1:0]    s_wen_o,
   output logic [NUM_S-1:0]    s_ren_o,
   input  logic [NUM_S*DW-1:0] s_rdata_i
);

   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   logic [MW-1:0] rr_ptr_q,   rr_ptr_d;
   logic          pend_vld_q, pend_vld_d;
   logic [MW-1:0] pend_m_q,   pend_m_d;
   logic [3:0]    pend_s_q,   pend_s_d;
   logic          pend_err_q, pend_err_d;

   logic          gnt_vld;
   logic [MW-1:0] gnt_idx;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_we;
   logic [3:0]    sel_s;
   logic          dec_err;
   logic [DW-1:0] rdata_sel;
   logic          rsp_vld;

   // Search order starts at rr_ptr (round-robin) or 0 (fixed). The loop walks the
   // order backwards so the last hit, which is the one kept, is the first in order.
   always_comb begin : arb
      int            base;
      int            cand;
      logic [MW-1:0] cand_idx;
      base     = (ARB_MODE == 1) ? int'(rr_ptr_q) : 0;
      cand     = 0;
      cand_idx = '0;
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      if (rst_n_i) begin
         for (int i = NUM_M - 1; i >= 0; i--) begin
            cand     = (base + i) % NUM_M;
            cand_idx = MW'(cand);
            if (m_req_i[cand_idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand_idx;
            end
         end
      end
   end

   always_comb begin
      sel_addr  = m_addr_i[gnt_idx*AW +: AW];
      sel_wdata = m_wdata_i[gnt_idx*DW +: DW];
      sel_we    = m_we_i[gnt_idx];
      sel_s     = sel_addr[AW-1 -: 4];
      dec_err   = ({1'b0, sel_s} >= 5'(NUM_S));
   end

   // Broadcast buses are zero when idle so slaves never see a floating address.
   // An out-of-range index matches no slave, which drops writes and mutes reads.
   always_comb begin
      m_gnt_o   = '0;
      s_wen_o   = '0;
      s_ren_o   = '0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      if (gnt_vld) begin
         m_gnt_o[gnt_idx] = 1'b1;
         s_addr_o         = {4'b0000, sel_addr[AW-5:0]};
         s_wdata_o        = sel_wdata;
         for (int s = 0; s < NUM_S; s++) begin
            if (sel_s == 4'(s)) begin
               s_wen_o[s] = sel_we;
               s_ren_o[s] = ~sel_we;
            end
         end
      end
   end

   assign m_hold_o = m_req_i & ~m_gnt_o;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         rr_ptr_d = (gnt_idx == MW'(NUM_M - 1)) ? '0 : gnt_idx + MW'(1);
      end
      // Decode-error reads still take a response slot (with err set).
      pend_vld_d = gnt_vld & ~sel_we;
      pend_m_d   = gnt_idx;
      pend_s_d   = sel_s;
      pend_err_d = dec_err;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rr_ptr_q   <= '0;
         pend_vld_q <= 1'b0;
         pend_m_q   <= '0;
         pend_s_q   <= '0;
         pend_err_q <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         pend_vld_q <= pend_vld_d;
         pend_m_q   <= pend_m_d;
         pend_s_q   <= pend_s_d;
         pend_err_q <= pend_err_d;
      end
   end

   always_comb begin
      rdata_sel = '0;
      for (int s = 0; s < NUM_S; s++) begin
         if (pend_s_q == 4'(s)) rdata_sel = s_rdata_i[s*DW +: DW];
      end
   end

   // A read granted just before reset asserts must not surface during the reset cycle.
   assign rsp_vld = pend_vld_q & rst_n_i;

   always_comb begin
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      m_err_o    = 1'b0;
      if (rsp_vld) begin
         m_rvalid_o[pend_m_q] = 1'b1;
         m_err_o              = pend_err_q;
         m_rdata_o            = pend_err_q ? '0 : rdata_sel;
      end
   end

endmodule

// File: tb/tb_rib_xbar.sv
module tb_rib_xbar;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Three instances: [0] NUM_M=2 round-robin, [1] NUM_M=2 fixed priority, [2] NUM_M=3 round-robin.
   logic [2:0]   req   [3];
   logic [2:0]   we    [3];
   logic [95:0]  addr  [3];
   logic [95:0]  wdata [3];
   logic [255:0] srdata[3];

   logic [2:0]   gnt_a [3];
   logic [2:0]   hold_a[3];
   logic [2:0]   rv_a  [3];
   logic [31:0]  rd_a  [3];
   logic         err_a [3];
   logic [31:0]  sa_a  [3];
   logic [31:0]  sw_a  [3];
   logic [7:0]   wen_a [3];
   logic [7:0]   ren_a [3];

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int NM = (g == 2) ? 3 : 2;
      localparam int AM = (g == 1) ? 0 : 1;
      logic [NM-1:0] gnt_w, hold_w, rv_w;
      rib_xbar #(.NUM_M(NM), .NUM_S(8), .ARB_MODE(AM), .AW(32), .DW(32)) u_dut (
         .clk_i      (clk),
         .rst_n_i    (rst_n),
         .m_req_i    (req[g][NM-1:0]),
         .m_we_i     (we[g][NM-1:0]),
         .m_addr_i   (addr[g][NM*32-1:0]),
         .m_wdata_i  (wdata[g][NM*32-1:0]),
         .m_gnt_o    (gnt_w),
         .m_hold_o   (hold_w),
         .m_rvalid_o (rv_w),
         .m_rdata_o  (rd_a[g]),
         .m_err_o    (err_a[g]),
         .s_addr_o   (sa_a[g]),
         .s_wdata_o  (sw_a[g]),
         .s_wen_o    (wen_a[g]),
         .s_ren_o    (ren_a[g]),
         .s_rdata_i  (srdata[g])
      );
      assign gnt_a[g]  = 3'(gnt_w);
      assign hold_a[g] = 3'(hold_w);
      assign rv_a[g]   = 3'(rv_w);
   end

   int total = 0;
   int bad   = 0;
   bit run_chk = 1'b0;

   task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL dut%0d %s got=%h want=%h t=%0t", g, nm, act, exp, $time);
      end
   endtask

   // Behavioural model: transaction-level view of each crossbar.
   int ptr  [3] = '{0, 0, 0};
   bit p_vld[3] = '{0, 0, 0};
   int p_m  [3];
   int p_s  [3];
   bit p_err[3];

   function automatic int arb(input int mode, input int nm, input int pt, input logic [2:0] r);
      int w;
      int c;
      w = -1;
      for (int i = 0; i < nm; i++) begin
         c = (mode == 0) ? i : (pt + i) % nm;
         if (w < 0 && r[c]) w = c;
      end
      return w;
   endfunction

   always @(negedge clk) begin
      int nm, mode, w, si;
      logic [2:0]  msk, r, xg, xr;
      logic [31:0] a, xsa, xsw, xrd;
      logic [7:0]  xwen, xren;
      logic        e, xerr;
      if (run_chk) begin
         for (int g = 0; g < 3; g++) begin
            nm   = (g == 2) ? 3 : 2;
            mode = (g == 1) ? 0 : 1;
            msk  = (nm == 3) ? 3'b111 : 3'b011;
            r    = req[g] & msk;
            w    = rst_n ? arb(mode, nm, ptr[g], r) : -1;
            xg = '0; xsa = '0; xsw = '0; xwen = '0; xren = '0; si = 0; e = 1'b0;
            if (w >= 0) begin
               a   = addr[g][w*32 +: 32];
               si  = int'(a[31:28]);
               e   = (si >= 8);
               xg  = 3'(1 << w);
               xsa = a & 32'h0FFF_FFFF;
               xsw = wdata[g][w*32 +: 32];
               if (!e) begin
                  if (we[g][w]) xwen = 8'(1 << si);
                  else          xren = 8'(1 << si);
               end
            end
            xr = '0; xrd = '0; xerr = 1'b0;
            if (p_vld[g] && rst_n) begin
               xr   = 3'(1 << p_m[g]);
               xerr = p_err[g];
               if (!p_err[g]) xrd = srdata[g][p_s[g]*32 +: 32];
            end
            chk(g, "gnt",    gnt_a[g],  32'(xg));
            chk(g, "hold",   hold_a[g], 32'(r & ~xg));
            chk(g, "saddr",  sa_a[g],   xsa);
            chk(g, "swdata", sw_a[g],   xsw);
            chk(g, "wen",    wen_a[g],  32'(xwen));
            chk(g, "ren",    ren_a[g],  32'(xren));
            chk(g, "rvalid", rv_a[g],   32'(xr));
            chk(g, "rdata",  rd_a[g],   xrd);
            chk(g, "err",    err_a[g],  32'(xerr));
            if (!rst_n) begin
               ptr[g]   = 0;
               p_vld[g] = 1'b0;
            end else begin
               if (w >= 0) ptr[g] = (w + 1) % nm;
               p_vld[g] = (w >= 0) && !we[g][w];
               p_m[g]   = w;
               p_s[g]   = si;
               p_err[g] = e;
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int g = 0; g < 3; g++) req[g] = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         req[g] = '0; we[g] = '0; addr[g] = '0; wdata[g] = '0;
         for (int k = 0; k < 8; k++) srdata[g][k*32 +: 32] = 32'h1000 + k;
      end
      repeat (3) @(posedge clk);
      #1;
      run_chk = 1'b1;
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      chk(0, "reset_rvalid", rv_a[0], 0);
      chk(0, "reset_rdata",  rd_a[0], 0);
      chk(0, "reset_err",    err_a[0], 0);
      nxt();

      // Round-robin alternation on dut0, fixed priority on dut1, same traffic.
      for (int g = 0; g < 2; g++) begin
         req[g]  = 3'b011;
         we[g]   = 3'b000;
         addr[g] = {32'h0, 32'h3000_0000, 32'h1000_0000};
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk(0, "rr_gnt", gnt_a[0], (i % 2 == 1) ? 32'd2 : 32'd1);
         if (i > 0) chk(0, "rr_rvalid", rv_a[0], (i % 2 == 1) ? 32'd1 : 32'd2);
         if (i == 1) chk(0, "rr_rdata_m0", rd_a[0], 32'h1001);
         chk(1, "fp_gnt", gnt_a[1], 32'd1);
         chk(1, "fp_hold1", hold_a[1][1], 1);
         nxt();
      end
      idle();
      @(negedge clk);
      chk(0, "rr_rvalid_last", rv_a[0], 32'd2);
      chk(0, "rr_rdata_m1", rd_a[0], 32'h1003);
      nxt();

      // Write to slave 2.
      req[0] = 3'b001; we[0] = 3'b001;
      addr[0][31:0]  = 32'h2000_0010;
      wdata[0][31:0] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk(0, "wr_wen",   wen_a[0], 32'h04);
      chk(0, "wr_ren",   ren_a[0], 0);
      chk(0, "wr_saddr", sa_a[0],  32'h0000_0010);
      chk(0, "wr_wdata", sw_a[0],  32'hDEAD_BEEF);
      nxt();
      idle();
      @(negedge clk);
      chk(0, "wr_wen_off",  wen_a[0], 0);
      chk(0, "wr_no_rsp",   rv_a[0],  0);
      nxt();

      // Decode-error read from master 1.
      req[0] = 3'b010; we[0] = 3'b000;
      addr[0][63:32] = 32'h9000_0000;
      @(negedge clk);
      chk(0, "derr_gnt", gnt_a[0], 32'd2);
      chk(0, "derr_ren", ren_a[0], 0);
      chk(0, "derr_wen", wen_a[0], 0);
      nxt();
      idle();
      @(negedge clk);
      chk(0, "derr_rvalid", rv_a[0], 32'd2);
      chk(0, "derr_err",    err_a[0], 1);
      chk(0, "derr_rdata",  rd_a[0], 0);
      nxt();

      // Read from M0 (pointer -> 1), then reset on the following edge.
      req[0] = 3'b001; we[0] = 3'b000;
      addr[0][31:0] = 32'h1000_0000;
      @(negedge clk);
      chk(0, "pre_rst_ren", ren_a[0], 32'h02);
      nxt();
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      chk(0, "rst_rvalid", rv_a[0], 0);
      nxt();
      rst_n = 1'b1;
      req[0] = 3'b011;
      @(negedge clk);
      chk(0, "post_rst_rvalid", rv_a[0], 0);
      chk(0, "post_rst_gnt",    gnt_a[0], 32'd1);
      nxt();
      idle();
      nxt();

      // Three-master wrap-around on dut2.
      req[2] = 3'b010; we[2] = 3'b000; addr[2] = '0;
      @(negedge clk);
      chk(2, "m3_gnt_m1", gnt_a[2], 32'd2);
      nxt();
      req[2] = 3'b011;
      @(negedge clk);
      chk(2, "m3_wrap_gnt", gnt_a[2], 32'd1);
      nxt();
      @(negedge clk);
      chk(2, "m3_ptr1_gnt", gnt_a[2], 32'd2);
      nxt();
      idle();

      // Random traffic, occasional resets.
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst_n = ($urandom_range(0, 199) != 0);
         for (int g = 0; g < 3; g++) begin
            req[g] = 3'($urandom_range(0, 7));
            we[g]  = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
               addr[g][k*32 +: 32]  = {4'($urandom_range(0, 9)), 28'($urandom)};
               wdata[g][k*32 +: 32] = $urandom;
            end
            for (int k = 0; k < 8; k++) srdata[g][k*32 +: 32] = $urandom;
         end
      end
      nxt();
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      nxt();
      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
